// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx serializer: FSM state encoding and a
// helper that sizes the bit counter.
package piso_pkg;

    // IDLE waits for a word; SHIFT presents one bit per cycle.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter width for a modulo-width bit counter (at least one bit).
    function automatic int cnt_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Parallel-in / serial-out link: word handshake toward the serializer and
// the registered serial stream coming back out of it.
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             sout;
    logic             sout_valid;
    logic             done;

    // Word source: offers words, observes readiness and the serial stream.
    modport master (
        output in_valid, in_data,
        input  in_ready, sout, sout_valid, done
    );

    // Serializer side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, sout, sout_valid, done
    );
endinterface

// File: rtl/tx_bit_counter.sv
// Modulo-WIDTH bit position counter. clear has priority over enable and
// forces the count back to zero; last flags the final bit position.
module tx_bit_counter
    import piso_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CW    = cnt_bits(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] MAX = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise advance and wrap after WIDTH-1.
    always_comb begin
        // NOTE: default assigned first so every path drives count_d; no latch.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == MAX) ? '0 : count_q + CW'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == MAX);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter. A word accepted on an edge appears
// on sout one bit per cycle starting the next cycle; a new word may be
// accepted on the edge that ends the last bit, giving a gapless stream.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input logic       clk,
    input logic       rst,
    piso_tx_if.slave  bus
);

    localparam int CW      = cnt_bits(WIDTH);
    localparam int OUT_IDX = LSB_FIRST ? 0 : WIDTH - 1;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             sout_valid_q;
    logic             sout_valid_d;
    logic             done_q;
    logic             done_d;

    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    // Ready when idle, or while presenting the last bit of the current word.
    assign in_ready = (state_q == IDLE) || cnt_last;
    assign accept   = bus.in_valid && in_ready;

    // Move the next bit into the output position; zeros fill in behind, so
    // the register is empty (sout = 0) once the last bit has gone out.
    assign shifted = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

    tx_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (state_q == SHIFT),
        .count  (cnt),
        .last   (cnt_last)
    );

    // Next state, shift register contents and registered output flags.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = bus.in_data;
                end
            end
            SHIFT: begin
                if (accept) begin
                    shreg_d = bus.in_data;
                end else begin
                    shreg_d = shifted;
                    if (cnt_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
            end
        endcase
        sout_valid_d = (state_d == SHIFT);
        // Next cycle presents the last bit when the counter is about to
        // reach WIDTH-1; a fresh acceptance restarts at bit 0 instead.
        done_d       = (state_d == SHIFT) && !accept && (cnt == CW'(WIDTH - 2));
    end

    // State, data and output flag registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.sout       = shreg_q[OUT_IDX];
    assign bus.sout_valid = sout_valid_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three instances (4-bit MSB-first, 4-bit LSB-first,
// 8-bit MSB-first) share one stimulus stream. Each instance has a bit-level
// scoreboard fed on acceptance plus a shift-in loopback receiver.
module tb_piso_tx;
    import piso_pkg::*;

    typedef struct packed {
        logic b;
        logic last;
    } bit_exp_t;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       in_valid_s = 1'b0;
    logic [7:0] in_data_s  = '0;
    bit         finishing  = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int W = (g == 2) ? 8 : 4;
        localparam bit L = (g == 1);

        piso_tx_if #(.WIDTH(W)) bus ();
        assign bus.in_valid = in_valid_s;
        assign bus.in_data  = in_data_s[W-1:0];

        piso_tx #(.WIDTH(W), .LSB_FIRST(L)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        bit_exp_t       exp_q[$];
        logic [W-1:0]   word_q[$];
        logic [W-1:0]   rx       = '0;
        bit             end_done = 1'b0;

        // Asynchronous reset must clear outputs before any clock edge.
        always @(posedge rst) begin
            #1;
            check($sformatf("i%0d async_rst sout", g), 32'(bus.sout), 32'd0);
            check($sformatf("i%0d async_rst sout_valid", g), 32'(bus.sout_valid), 32'd0);
            check($sformatf("i%0d async_rst done", g), 32'(bus.done), 32'd0);
            check($sformatf("i%0d async_rst in_ready", g), 32'(bus.in_ready), 32'd1);
            check($sformatf("i%0d async_rst state", g), 32'(dut.state_q), 32'(IDLE));
        end

        // Monitor: compare the presented bit, then model acceptance.
        always @(negedge clk) begin
            bit_exp_t     e;
            logic         ev;
            logic         exp_rdy;
            logic [W-1:0] w;
            logic [W-1:0] want;
            if (rst) begin
                exp_q.delete();
                word_q.delete();
                rx = '0;
                check($sformatf("i%0d rst sout_valid", g), 32'(bus.sout_valid), 32'd0);
                check($sformatf("i%0d rst done", g), 32'(bus.done), 32'd0);
                check($sformatf("i%0d rst sout", g), 32'(bus.sout), 32'd0);
            end else begin
                ev = (exp_q.size() != 0);
                e  = ev ? exp_q.pop_front() : '0;
                check($sformatf("i%0d sout_valid", g), 32'(bus.sout_valid), 32'(ev));
                check($sformatf("i%0d sout", g), 32'(bus.sout), 32'(e.b));
                check($sformatf("i%0d done", g), 32'(bus.done), 32'(e.last));
                exp_rdy = (exp_q.size() == 0);
                check($sformatf("i%0d in_ready", g), 32'(bus.in_ready), 32'(exp_rdy));

                if (bus.sout_valid) begin
                    rx = {rx[W-2:0], bus.sout};
                end
                if (bus.done) begin
                    check($sformatf("i%0d done_has_word", g), 32'(word_q.size() != 0), 32'd1);
                    if (word_q.size() != 0) begin
                        w = word_q.pop_front();
                        for (int i = 0; i < W; i++) begin
                            want[i] = L ? w[W-1-i] : w[i];
                        end
                        check($sformatf("i%0d loopback", g), 32'(rx), 32'(want));
                    end
                end

                if (in_valid_s && exp_rdy) begin
                    word_q.push_back(in_data_s[W-1:0]);
                    for (int i = 0; i < W; i++) begin
                        exp_q.push_back('{b: (L ? in_data_s[i] : in_data_s[W-1-i]),
                                          last: (i == W - 1)});
                    end
                end

                if (finishing && !end_done) begin
                    end_done = 1'b1;
                    check($sformatf("i%0d bits_drained", g), 32'(exp_q.size()), 32'd0);
                    check($sformatf("i%0d words_drained", g), 32'(word_q.size()), 32'd0);
                end
            end
        end
    end

    // Drive one cycle's inputs just after the active edge.
    task automatic cyc(input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        in_valid_s = v;
        in_data_s  = d;
    endtask

    // Pulse reset between clock edges, releasing it before the next edge.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst        = 1'b1;
        in_valid_s = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Directed sequences followed by randomized traffic.
    initial begin
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;

        // Single word 4'b1011, valid for one cycle.
        cyc(1'b1, 8'h0B);
        repeat (10) cyc(1'b0, 8'($urandom));

        // Held valid: 4'hA then 4'h5 back to back.
        cyc(1'b1, 8'h0A);
        repeat (4) cyc(1'b1, 8'h05);
        repeat (10) cyc(1'b0, 8'h00);

        // Single-bit word, exercises bit order on the LSB-first instance.
        cyc(1'b1, 8'h01);
        repeat (10) cyc(1'b0, 8'h00);

        // 4'hF interrupted by reset during bit 2, then 4'h3.
        cyc(1'b1, 8'h0F);
        cyc(1'b0, 8'h00);
        mid_reset();
        cyc(1'b1, 8'h03);
        repeat (10) cyc(1'b0, 8'h00);

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            if (n % 97 == 50) begin
                mid_reset();
            end else begin
                cyc(($urandom_range(0, 3) != 0), 8'($urandom));
            end
        end

        repeat (12) cyc(1'b0, 8'h00);
        finishing = 1'b1;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: WIDTH, 4, word width in bits; SHALL be >= 2.
REQ-002 Parameter: LSB_FIRST, 0, bit order; 0 = MSB first, 1 = LSB first.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: in_valid  input  1  parallel word offered.
REQ-006 Port: in_data  input  WIDTH  parallel word to serialize.
REQ-007 Port: in_ready  output  1  block can accept a word this cycle.
REQ-008 Port: sout  output  1  serial data bit, registered.
REQ-009 Port: sout_valid  output  1  sout carries a valid bit this cycle, registered.
REQ-010 Port: done  output  1  one-cycle pulse on the last bit of each word, registered.

Function
REQ-011 FSM SHALL have two states: IDLE and SHIFT.
REQ-012 IDLE: in_ready = 1; sout_valid = 0; sout = 0; done = 0.
REQ-013 Handshake: a word SHALL be accepted on a rising edge where in_valid && in_ready; in_data is captured into the shift register at that edge; later changes to in_data SHALL be ignored.
REQ-014 in_valid while in_ready = 0 SHALL be ignored, with no capture and no state change.
REQ-015 On acceptance from IDLE: go to SHIFT; bit counter = 0; the first bit SHALL appear on sout, with sout_valid = 1, in the cycle after the accepting edge (latency 1).
REQ-016 Bit order: LSB_FIRST = 0 sends in_data[WIDTH-1] down to in_data[0]; LSB_FIRST = 1 sends in_data[0] up to in_data[WIDTH-1].
REQ-017 SHIFT: each edge advances one bit; counter increments modulo WIDTH; sout_valid stays 1 for exactly WIDTH consecutive cycles per word.
REQ-018 done SHALL be 1 only during the cycle presenting the last bit (counter = WIDTH-1).
REQ-019 in_ready in SHIFT SHALL be 1 only when counter = WIDTH-1; it is combinational from state and counter, never from in_valid.
REQ-020 Back-to-back: acceptance at the last-bit edge SHALL reload the shift register and restart counter = 0 in SHIFT, giving gapless output with no idle cycle between words.
REQ-021 Last bit with no acceptance: return to IDLE; sout_valid = 0 next cycle.
REQ-022 Counter width SHALL be $clog2(WIDTH); counter SHALL never exceed WIDTH-1.

Reset
REQ-023 Asserting rst SHALL immediately, without waiting for clk, force: state IDLE, counter 0, shift register 0, sout 0, sout_valid 0, done 0.
REQ-024 Reset mid-word SHALL discard the remaining bits; no partial-word resumption after release.
REQ-025 First edge after rst deasserts SHALL behave as IDLE (in_ready = 1, acceptance permitted).

Structure
REQ-026 State encodings (IDLE = 0, SHIFT = 1) SHALL live in a shared package/header, piso_pkg, for reuse by the bench.
REQ-027 The modulo-WIDTH bit counter SHALL be one sub-module, tx_bit_counter (inputs clear, enable; outputs count, last), with everything else inline.

Verification (WIDTH = 4 unless stated)
REQ-028 rst pulsed between clock edges while shifting -> sout, sout_valid, done drop to 0 before the next edge; in_ready = 1.
REQ-029 Accept 4'b1011, in_valid for one cycle -> sout 1,0,1,1 on cycles 1-4; sout_valid high cycles 1-4; done on cycle 4 only; in_ready 0 on cycles 1-3.
REQ-030 in_valid held with 4'hA then 4'h5 -> 8 contiguous valid bits 1,0,1,0,0,1,0,1; done on cycles 4 and 8; no gap.
REQ-031 LSB_FIRST = 1, accept 4'b0001 -> sout 1,0,0,0; done on the 4th bit.
REQ-032 Accept 4'hF, assert rst during bit 2, release, accept 4'h3 -> no further bits of 4'hF appear; then 0,0,1,1.
REQ-033 Loopback into a 4-bit shift-in receiver (new bit enters at position 0 when sout_valid) over random words, including WIDTH = 8 -> the receiver word equals the sent word after each done.
